// File: rtl/friet_pc_inverse_permutation_if.sv
// friet_pc_inverse_permutation_if: request/result bundle for the Friet-PC inverse.
// Optional: FRIET_PC_INV_ABORT_EN adds the abort request line.
interface friet_pc_inverse_permutation_if;
    localparam int unsigned STATE_W = 384;
    localparam int unsigned RC_W    = 5;

    logic               start;
    logic               start_ready;
    logic [STATE_W-1:0] din;
    logic [RC_W-1:0]    rc_index;
    logic [RC_W-1:0]    rc;
    logic [STATE_W-1:0] dout;
    logic               dout_valid;
    logic               dout_ready;
`ifdef FRIET_PC_INV_ABORT_EN
    logic               abort;
`endif

    // Requester / consumer side
    modport master (
`ifdef FRIET_PC_INV_ABORT_EN
        output abort,
`endif
        output start, din, rc, dout_ready,
        input  start_ready, rc_index, dout, dout_valid
    );

    // Permutation engine side
    modport slave (
`ifdef FRIET_PC_INV_ABORT_EN
        input  abort,
`endif
        input  start, din, rc, dout_ready,
        output start_ready, rc_index, dout, dout_valid
    );
endinterface

// File: rtl/friet_pc_inverse_permutation.sv
// friet_pc_inverse_permutation: iterative inverse of the Friet-PC permutation,
// one inverse round per clock with the round index counting down ROUNDS-1..0.
// Optional: define FRIET_PC_INV_ABORT_EN to add an abort input.
module friet_pc_inverse_permutation #(
    parameter int unsigned ROUNDS = 24
) (
    input logic                           clk,
    input logic                           rst,
    friet_pc_inverse_permutation_if.slave bus
);
    localparam int unsigned LANE_W  = 128;
    localparam int unsigned STATE_W = 3 * LANE_W;
    localparam int unsigned CNT_W   = 5;
    localparam logic [CNT_W-1:0] LAST_ROUND = CNT_W'(ROUNDS - 1);

    typedef logic [LANE_W-1:0] lane_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    // Rotate right: result bit i takes x[i+n]
    function automatic lane_t rotr(input lane_t x, input int unsigned n);
        return (x >> n) | (x << (LANE_W - n));
    endfunction

    // Rotate left: result bit i takes x[i-n]
    function automatic lane_t rotl(input lane_t x, input int unsigned n);
        return (x << n) | (x >> (LANE_W - n));
    endfunction

    // One inverse round; undoes the forward round that used the same rc
    function automatic logic [STATE_W-1:0] inv_round(input logic [STATE_W-1:0] s,
                                                     input logic [CNT_W-1:0]   rc);
        lane_t in_a, in_b, in_c;
        lane_t t, f, a, cp, b, c, rc_mask;
        in_a    = s[LANE_W-1:0];
        in_b    = s[2*LANE_W-1:LANE_W];
        in_c    = s[STATE_W-1:2*LANE_W];
        t       = in_a ^ (rotr(in_c, 61) & rotr(in_b, 92));
        f       = in_b ^ in_c ^ t;
        a       = in_c ^ rotr(f, 48);
        cp      = f ^ rotl(a, 1);
        b       = t ^ a ^ cp;
        // rc[3:0] sit on every fourth bit, in the low or the next nibble group
        rc_mask = LANE_W'({rc[3], 3'b000, rc[2], 3'b000, rc[1], 3'b000, rc[0]});
        if (rc[4]) begin
            rc_mask = rc_mask << 16;
        end
        c       = cp ^ rc_mask;
        return {c, b, a};
    endfunction

    fsm_t               fsm;
    logic [STATE_W-1:0] state_q;
    logic [CNT_W-1:0]   counter;
    logic [STATE_W-1:0] dout_q;
    logic               dout_valid_q;
    logic               start_ready_q;
    logic [STATE_W-1:0] round_c;
    logic               abort_req;

    // Next state of the permutation for the round currently addressed
    assign round_c = inv_round(state_q, bus.rc);

`ifdef FRIET_PC_INV_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    // Control FSM, round counter, state register and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm           <= IDLE;
            state_q       <= '0;
            counter       <= '0;
            dout_q        <= '0;
            dout_valid_q  <= 1'b0;
            start_ready_q <= 1'b1;
        end else if (abort_req && (fsm != IDLE)) begin
            fsm           <= IDLE;
            state_q       <= '0;
            counter       <= '0;
            dout_q        <= '0;
            dout_valid_q  <= 1'b0;
            start_ready_q <= 1'b1;
        end else begin
            case (fsm)
                IDLE: begin
                    if (bus.start && !abort_req) begin
                        state_q       <= bus.din;
                        counter       <= LAST_ROUND;
                        start_ready_q <= 1'b0;
                        fsm           <= RUN;
                    end
                end
                RUN: begin
                    state_q <= round_c;
                    if (counter == '0) begin
                        dout_q       <= round_c;
                        dout_valid_q <= 1'b1;
                        fsm          <= DONE;
                    end else begin
                        counter <= counter - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.dout_ready) begin
                        dout_valid_q  <= 1'b0;
                        start_ready_q <= 1'b1;
                        fsm           <= IDLE;
                    end
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

    assign bus.start_ready = start_ready_q;
    assign bus.rc_index    = counter;
    assign bus.dout        = dout_q;
    assign bus.dout_valid  = dout_valid_q;

endmodule

// File: tb/tb_friet_pc_inverse_permutation.sv
// tb_friet_pc_inverse_permutation: scoreboard bench for the Friet-PC inverse,
// with a ROUNDS=1 instance and a ROUNDS=24 instance on one clock.
// Optional: FRIET_PC_INV_ABORT_EN enables the abort scenarios.
module tb_friet_pc_inverse_permutation;
    typedef logic [127:0] lane_t;
    typedef logic [383:0] st_t;

    logic clk = 1'b0;
    logic rst1;
    logic rst24;
    int   errors = 0;
    int   checks = 0;
    st_t  exp1[$];
    st_t  exp24[$];

    always #5 clk = ~clk;

    friet_pc_inverse_permutation_if if1();
    friet_pc_inverse_permutation_if if24();

    friet_pc_inverse_permutation #(.ROUNDS(1)) u_dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (if1)
    );

    friet_pc_inverse_permutation #(.ROUNDS(24)) u_dut24 (
        .clk (clk),
        .rst (rst24),
        .bus (if24)
    );

    // Shared round-constant table, mixing both rc[4] settings
    function automatic logic [4:0] rc_of(input int i);
        return 5'((i * 11 + 5) % 32);
    endfunction

    assign if24.rc = rc_of(32'(if24.rc_index));

    // ---------------- reference model, straight from the round equations ----
    function automatic lane_t m_rotr(input lane_t x, input int n);
        lane_t r;
        for (int i = 0; i < 128; i++) r[i] = x[(i + n) % 128];
        return r;
    endfunction

    function automatic lane_t m_rotl(input lane_t x, input int n);
        lane_t r;
        for (int i = 0; i < 128; i++) r[i] = x[(i - n + 128) % 128];
        return r;
    endfunction

    function automatic lane_t m_rcmask(input logic [4:0] rc);
        lane_t m;
        int    base;
        m    = '0;
        base = rc[4] ? 16 : 0;
        for (int j = 0; j < 4; j++) m[base + 4 * j] = rc[j];
        return m;
    endfunction

    function automatic st_t m_inv(input st_t s, input logic [4:0] rc);
        lane_t in_a, in_b, in_c, t, f, a, cp, b, c;
        in_a = s[127:0];
        in_b = s[255:128];
        in_c = s[383:256];
        t    = in_a ^ (m_rotr(in_c, 61) & m_rotr(in_b, 92));
        f    = in_b ^ in_c ^ t;
        a    = in_c ^ m_rotr(f, 48);
        cp   = f ^ m_rotl(a, 1);
        b    = t ^ a ^ cp;
        c    = cp ^ m_rcmask(rc);
        return {c, b, a};
    endfunction

    // Forward round: the inverse equations solved backwards
    function automatic st_t m_fwd(input st_t s, input logic [4:0] rc);
        lane_t a, b, c, cp, t, f, out_a, out_b, out_c;
        a     = s[127:0];
        b     = s[255:128];
        c     = s[383:256];
        cp    = c ^ m_rcmask(rc);
        t     = b ^ a ^ cp;
        f     = cp ^ m_rotl(a, 1);
        out_c = a ^ m_rotr(f, 48);
        out_b = f ^ out_c ^ t;
        out_a = t ^ (m_rotr(out_c, 61) & m_rotr(out_b, 92));
        return {out_c, out_b, out_a};
    endfunction

    function automatic st_t m_fwd24(input st_t s);
        st_t x;
        x = s;
        for (int i = 0; i < 24; i++) x = m_fwd(x, rc_of(i));
        return x;
    endfunction

    function automatic st_t m_inv24(input st_t s);
        st_t x;
        x = s;
        for (int i = 23; i >= 0; i--) x = m_inv(x, rc_of(i));
        return x;
    endfunction

    function automatic st_t rand384();
        st_t r;
        for (int i = 0; i < 12; i++) r[32 * i +: 32] = $urandom;
        return r;
    endfunction

    // ---------------- comparison helpers ----------------
    task automatic check_st(input string name, input st_t act, input st_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic check_v(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitors ----------------
    logic hs1;
    logic hs24;
`ifdef FRIET_PC_INV_ABORT_EN
    assign hs1  = if1.dout_valid && if1.dout_ready && !if1.abort && !rst1;
    assign hs24 = if24.dout_valid && if24.dout_ready && !if24.abort && !rst24;
`else
    assign hs1  = if1.dout_valid && if1.dout_ready && !rst1;
    assign hs24 = if24.dout_valid && if24.dout_ready && !rst24;
`endif

    always @(negedge clk) begin
        if (hs1) begin
            if (exp1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb1_unexpected: got %h required no result", if1.dout);
            end else begin
                check_st("sb1_dout", if1.dout, exp1.pop_front());
            end
        end
        if (hs24) begin
            if (exp24.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb24_unexpected: got %h required no result", if24.dout);
            end else begin
                check_st("sb24_dout", if24.dout, exp24.pop_front());
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic wait_idle(input bit big);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        while (!(big ? if24.start_ready : if1.start_ready) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!(big ? if24.start_ready : if1.start_ready)) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: start_ready=0 required 1 (big=%0d)", big);
        end
    endtask

    task automatic run1(input st_t d, input logic [4:0] r, input st_t e,
                        input string tag, output st_t got);
        wait_idle(1'b0);
        if1.rc    = r;
        if1.din   = d;
        if1.start = 1'b1;
        exp1.push_back(e);
        @(posedge clk);
        #1 if1.start = 1'b0;
        @(negedge clk);
        check_v({tag, "_run"}, 32'({if1.dout_valid, if1.start_ready, if1.rc_index}), 32'h0);
        @(negedge clk);
        got = if1.dout;
        check_v({tag, "_valid"}, 32'(if1.dout_valid), 32'h1);
        @(negedge clk);
        check_v({tag, "_after"}, 32'({if1.dout_valid, if1.start_ready}), 32'h1);
    endtask

    task automatic launch24(input st_t d, input st_t e, input bit push);
        wait_idle(1'b1);
        if24.din   = d;
        if24.start = 1'b1;
        if (push) exp24.push_back(e);
        @(posedge clk);
        #1 if24.start = 1'b0;
    endtask

    // 24 RUN cycles: rc_index counts 23..0, no result, not ready
    task automatic watch_run24(output bit ok);
        ok = 1'b1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (if24.rc_index !== 5'(23 - i) || if24.dout_valid !== 1'b0 ||
                if24.start_ready !== 1'b0) ok = 1'b0;
        end
    endtask

    task automatic run24(input st_t d, input st_t e);
        bit ok;
        launch24(d, e, 1'b1);
        watch_run24(ok);
        check_v("rc_seq24", 32'(ok), 32'h1);
        @(negedge clk);
        check_v("lat24", 32'(if24.dout_valid), 32'h1);
        @(negedge clk);
        check_v("valid_1cyc", 32'({if24.dout_valid, if24.start_ready}), 32'h1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        st_t        d;
        st_t        orig;
        st_t        got;
        logic [4:0] r;
        bit         ok;

        rst1            = 1'b0;
        rst24           = 1'b0;
        if1.start       = 1'b0;
        if1.din         = '0;
        if1.rc          = '0;
        if1.dout_ready  = 1'b1;
        if24.start      = 1'b0;
        if24.din        = '0;
        if24.dout_ready = 1'b1;
`ifdef FRIET_PC_INV_ABORT_EN
        if1.abort       = 1'b0;
        if24.abort      = 1'b0;
`endif
        #1;
        rst1  = 1'b1;
        rst24 = 1'b1;
        repeat (2) @(negedge clk);
        check_v("rst1_ctl", 32'({if1.dout_valid, if1.start_ready, if1.rc_index}), 32'h20);
        check_st("rst1_dout", if1.dout, '0);
        check_v("rst24_ctl", 32'({if24.dout_valid, if24.start_ready, if24.rc_index}), 32'h20);
        check_st("rst24_dout", if24.dout, '0);
        #2;
        rst1  = 1'b0;
        rst24 = 1'b0;

        // Single-round instance
        d = (st_t'(1) << 336) | (st_t'(1) << 208) | st_t'(1);
        run1(d, 5'h01, '0, "t1_sparse", got);
        run1('0, 5'h00, '0, "t1_zero", got);
        run1('1, 5'h00, m_inv('1, 5'h00), "t1_ones", got);
        check_st("t1_fwd_ones", m_fwd(got, 5'h00), '1);
        for (int i = 0; i < 10; i++) begin
            d = rand384();
            r = 5'($urandom_range(0, 31));
            run1(d, r, m_inv(d, r), "t1_rand", got);
        end

        // Full permutation: round trips and direct inverses
        for (int i = 0; i < 50; i++) begin
            orig = rand384();
            run24(m_fwd24(orig), orig);
        end
        for (int i = 0; i < 3; i++) begin
            d = rand384();
            run24(d, m_inv24(d));
        end

        // Backpressure with start pulsed while busy
        if24.dout_ready = 1'b0;
        orig = rand384();
        launch24(m_fwd24(orig), orig, 1'b1);
        if24.start = 1'b1;
        watch_run24(ok);
        check_v("bp_rc_seq", 32'(ok), 32'h1);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (if24.dout_valid !== 1'b1 || if24.dout !== orig || if24.start_ready !== 1'b0) ok = 1'b0;
        end
        check_v("bp_hold", 32'(ok), 32'h1);
        @(posedge clk);
        #1;
        if24.start      = 1'b0;
        if24.dout_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_v("bp_release", 32'({if24.dout_valid, if24.start_ready}), 32'h1);

        // Asynchronous reset in the middle of RUN
        launch24(rand384(), '0, 1'b0);
        repeat (12) @(posedge clk);
        #3 rst24 = 1'b1;
        #1;
        check_v("rst_mid_ctl", 32'({if24.dout_valid, if24.start_ready, if24.rc_index}), 32'h20);
        check_st("rst_mid_dout", if24.dout, '0);
        @(negedge clk);
        #2 rst24 = 1'b0;
        orig = rand384();
        run24(m_fwd24(orig), orig);

`ifdef FRIET_PC_INV_ABORT_EN
        // Abort in RUN cycle 5
        orig = rand384();
        launch24(m_fwd24(orig), '0, 1'b0);
        repeat (4) @(posedge clk);
        #1 if24.abort = 1'b1;
        @(posedge clk);
        #1 if24.abort = 1'b0;
        @(negedge clk);
        check_v("abort_run_ctl", 32'({if24.dout_valid, if24.start_ready, if24.rc_index}), 32'h20);
        check_st("abort_run_dout", if24.dout, '0);
        ok = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (if24.dout_valid !== 1'b0) ok = 1'b0;
        end
        check_v("abort_no_valid", 32'(ok), 32'h1);

        // Abort together with dout_ready in DONE
        if24.dout_ready = 1'b0;
        launch24(m_fwd24(orig), '0, 1'b0);
        watch_run24(ok);
        check_v("abort_done_seq", 32'(ok), 32'h1);
        @(negedge clk);
        check_st("abort_done_dout", if24.dout, orig);
        @(posedge clk);
        #1;
        if24.abort      = 1'b1;
        if24.dout_ready = 1'b1;
        @(posedge clk);
        #1 if24.abort = 1'b0;
        @(negedge clk);
        check_v("abort_done_ctl", 32'({if24.dout_valid, if24.start_ready}), 32'h1);
        check_st("abort_done_clr", if24.dout, '0);

        // Abort in IDLE blocks a start in the same cycle
        @(posedge clk);
        #1;
        if24.abort = 1'b1;
        if24.start = 1'b1;
        @(posedge clk);
        #1;
        if24.abort = 1'b0;
        if24.start = 1'b0;
        @(negedge clk);
        check_v("abort_idle", 32'({if24.start_ready, if24.rc_index}), 32'h20);
`endif

        repeat (4) @(negedge clk);
        check_v("sb1_drain", 32'(exp1.size()), 32'h0);
        check_v("sb24_drain", 32'(exp24.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
